pipe_hazard_ctrl: RTL and testbench

//  Parametrised scoreboard-based hazard/interlock controller for the in-order RISC-V pipeline.
//  It generalises the fixed 5-stage load-use hazard logic to N stages and configurable load latency.
//  It adds multi-cycle EX support (ex_busy), ECALL drain-and-halt, and a stall-cycle counter.
//  It sits beside the pipeline registers and drives PC enable, IF/ID hold/flush and bubble insertion.

---
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard hazard/interlock controller for the in-order pipeline.
// Handles load-use stalls, multi-cycle EX, ECALL drain/halt and stall accounting.
module pipe_hazard_ctrl #(
  parameter int STAGES   = 5,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_is_ecall,
  input  logic              id_redirect,
  input  logic              ex_busy,
  output logic              pc_enable,
  output logic              hold_ifid,
  output logic              flush_ifid,
  output logic              bubble_idex,
  output logic              bubble_exmem,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [STAGES-3:0] inflight_valid
);

  localparam int N  = STAGES - 2;
  localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT + 1) : 1;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic [CW-1:0]    cnt;
    logic             ecall;
  } sb_t;

  sb_t              sb_q [N];
  sb_t              sb_d [N];
  sb_t              ex_new;
  logic             draining_q, draining_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             m1, m2, hazard, issue, stall_inc;

  function automatic sb_t adv(sb_t e);
    sb_t r;
    r = e;
    if (e.cnt != '0) r.cnt = e.cnt - CW'(1);
    return r;
  endfunction

  // Oldest-to-youngest scan: the youngest matching writer wins.
  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sb_q[i].valid && sb_q[i].wr && sb_q[i].rd == id_rs1)
        m1 = (sb_q[i].cnt != '0);
      if (sb_q[i].valid && sb_q[i].wr && sb_q[i].rd == id_rs2)
        m2 = (sb_q[i].cnt != '0);
    end
    m1 = m1 & id_rs1_used & (id_rs1 != '0);
    m2 = m2 & id_rs2_used & (id_rs2 != '0);
  end

  assign hazard = id_valid & ~draining_q & (m1 | m2);
  assign issue  = id_valid & ~hazard & ~ex_busy & ~draining_q;

  always_comb begin
    ex_new       = '0;
    ex_new.valid = 1'b1;
    ex_new.rd    = id_rd;
    ex_new.wr    = id_reg_write & (id_rd != '0);
    ex_new.cnt   = id_is_load ? CW'(LOAD_LAT) : '0;
    ex_new.ecall = id_is_ecall;
  end

  always_comb begin
    for (int i = 1; i < N; i++) sb_d[i] = adv(sb_q[i-1]);
    if (ex_busy) begin
      sb_d[0] = sb_q[0];
      sb_d[1] = '0;
    end else begin
      sb_d[0] = issue ? ex_new : '0;
    end
  end

  assign draining_d = draining_q | (sb_q[0].valid & sb_q[0].ecall);
  assign halted_d   = halted_q | (sb_q[N-1].valid & sb_q[N-1].ecall);
  assign stall_inc  = (hazard | ex_busy) & ~halted_q;
  assign stall_d    = stall_q + {{(CNT_W-1){1'b0}}, stall_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) sb_q[i] <= '0;
      draining_q <= 1'b0;
      halted_q   <= 1'b0;
      stall_q    <= '0;
    end else begin
      for (int i = 0; i < N; i++) sb_q[i] <= sb_d[i];
      draining_q <= draining_d;
      halted_q   <= halted_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    pc_enable    = ~draining_q;
    hold_ifid    = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    unique case (1'b1)
      ex_busy: begin
        pc_enable    = 1'b0;
        hold_ifid    = 1'b1;
        bubble_exmem = 1'b1;
      end
      hazard: begin
        pc_enable   = 1'b0;
        hold_ifid   = 1'b1;
        bubble_idex = 1'b1;
      end
      default: ;
    endcase
  end

  assign flush_ifid   = (id_redirect & ~hazard & ~ex_busy) | draining_q;
  assign halted       = halted_q;
  assign stall_cycles = stall_q;

  always_comb begin
    inflight_valid = '0;
    for (int i = 0; i < N; i++) inflight_valid[i] = sb_q[i].valid;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a = (5 stages, lat 1), b = (6 stages, lat 2).
// Both instances share one stimulus stream.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, rs1_used, rs2_used, reg_write, is_load, is_ecall;
  logic       redirect, ex_busy;
  logic [4:0] rs1, rs2, rd;

  logic        a_pc, a_hold, a_flush, a_bidex, a_bexm, a_halted;
  logic [31:0] a_stall;
  logic [2:0]  a_infl;
  logic        b_pc, b_hold, b_flush, b_bidex, b_bexm, b_halted;
  logic [31:0] b_stall;
  logic [3:0]  b_infl;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.STAGES(5), .LOAD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_used(rs1_used), .id_rs2_used(rs2_used),
    .id_rd(rd), .id_reg_write(reg_write), .id_is_load(is_load),
    .id_is_ecall(is_ecall), .id_redirect(redirect), .ex_busy(ex_busy),
    .pc_enable(a_pc), .hold_ifid(a_hold), .flush_ifid(a_flush),
    .bubble_idex(a_bidex), .bubble_exmem(a_bexm), .halted(a_halted),
    .stall_cycles(a_stall), .inflight_valid(a_infl)
  );

  pipe_hazard_ctrl #(.STAGES(6), .LOAD_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_used(rs1_used), .id_rs2_used(rs2_used),
    .id_rd(rd), .id_reg_write(reg_write), .id_is_load(is_load),
    .id_is_ecall(is_ecall), .id_redirect(redirect), .ex_busy(ex_busy),
    .pc_enable(b_pc), .hold_ifid(b_hold), .flush_ifid(b_flush),
    .bubble_idex(b_bidex), .bubble_exmem(b_bexm), .halted(b_halted),
    .stall_cycles(b_stall), .inflight_valid(b_infl)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] d, input logic w,
                     input logic ld, input logic ec,
                     input logic [4:0] s1, input logic u1,
                     input logic [4:0] s2, input logic u2);
    id_valid  = v;
    rd        = d;
    reg_write = w;
    is_load   = ld;
    is_ecall  = ec;
    rs1       = s1;
    rs1_used  = u1;
    rs2       = s2;
    rs2_used  = u2;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic drain_pipe();
    idle();
    repeat (5) tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    redirect = 1'b0;
    ex_busy  = 1'b0;
    idle();
    #3;
    check("rst_pc",    a_pc, 1);
    check("rst_hold",  a_hold, 0);
    check("rst_flush", a_flush, 0);
    check("rst_bidex", a_bidex, 0);
    check("rst_bexm",  a_bexm, 0);
    check("rst_halt",  a_halted, 0);
    check("rst_stall", a_stall, 0);
    check("rst_infl",  a_infl, 0);
    check("rst_b_infl", b_infl, 0);
    tick();
    rst_n = 1'b1;

    // load-use: lw x5 ; add x6,x5,x1
    drv(1, 5'd5, 1, 1, 0, 5'd1, 1, 5'd0, 0);
    #2 check("lu0_pc", a_pc, 1);
    tick();
    drv(1, 5'd6, 1, 0, 0, 5'd5, 1, 5'd1, 1);
    #2;
    check("lu1_pc",    a_pc, 0);
    check("lu1_hold",  a_hold, 1);
    check("lu1_bidex", a_bidex, 1);
    check("lu1_bexm",  a_bexm, 0);
    check("lu1_stall", a_stall, 0);
    check("lu1_b_pc",  b_pc, 0);
    tick();
    #2;
    check("lu2_pc",     a_pc, 1);
    check("lu2_bidex",  a_bidex, 0);
    check("lu2_stall",  a_stall, 1);
    check("lu2_b_pc",   b_pc, 0);
    check("lu2_b_stall", b_stall, 1);
    tick();
    #2;
    check("lu3_b_pc",    b_pc, 1);
    check("lu3_b_stall", b_stall, 2);
    check("lu3_pc",      a_pc, 1);
    tick();
    drain_pipe();
    #2 check("lu_empty", a_infl, 0);

    // shadowing: lw x7 ; addi x7,x0 ; add x8,x7
    drv(1, 5'd7, 1, 1, 0, 5'd0, 0, 5'd0, 0);
    tick();
    drv(1, 5'd7, 1, 0, 0, 5'd0, 1, 5'd0, 0);
    #2 check("sh1_b_pc", b_pc, 1);
    tick();
    drv(1, 5'd8, 1, 0, 0, 5'd7, 1, 5'd0, 0);
    #2;
    check("sh2_b_pc",    b_pc, 1);
    check("sh2_b_bidex", b_bidex, 0);
    check("sh2_pc",      a_pc, 1);
    tick();
    drain_pipe();

    // x0 destination never blocks
    drv(1, 5'd0, 1, 1, 0, 5'd0, 0, 5'd0, 0);
    tick();
    drv(1, 5'd3, 1, 0, 0, 5'd0, 1, 5'd0, 1);
    #2;
    check("x0_pc",    a_pc, 1);
    check("x0_bidex", a_bidex, 0);
    check("x0_infl",  a_infl, 3'b001);
    tick();
    drain_pipe();

    // rs2 hazard, rs1 unused
    drv(1, 5'd9, 1, 1, 0, 5'd0, 0, 5'd0, 0);
    tick();
    drv(1, 5'd4, 1, 0, 0, 5'd9, 0, 5'd9, 1);
    #2;
    check("rs2_pc",    a_pc, 0);
    check("rs2_bidex", a_bidex, 1);
    check("rs2_b_pc",  b_pc, 0);
    tick();
    drv(1, 5'd4, 1, 0, 0, 5'd9, 0, 5'd3, 1);
    #2;
    check("unused_b_pc",  b_pc, 1);
    check("unused_stall", a_stall, 2);
    check("unused_b_stall", b_stall, 3);
    tick();
    drain_pipe();

    // multi-cycle EX: div x10 busy for 3 cycles
    drv(1, 5'd10, 1, 0, 0, 5'd1, 1, 5'd2, 1);
    tick();
    drv(1, 5'd11, 1, 0, 0, 5'd1, 1, 5'd2, 1);
    ex_busy = 1'b1;
    #2;
    check("bz1_pc",    a_pc, 0);
    check("bz1_hold",  a_hold, 1);
    check("bz1_bidex", a_bidex, 0);
    check("bz1_bexm",  a_bexm, 1);
    tick();
    redirect = 1'b1;
    #2;
    check("bz2_infl",  a_infl, 3'b001);
    check("bz2_flush", a_flush, 0);
    check("bz2_bexm",  a_bexm, 1);
    tick();
    redirect = 1'b0;
    #2 check("bz3_pc", a_pc, 0);
    tick();
    ex_busy = 1'b0;
    #2;
    check("bz4_pc",      a_pc, 1);
    check("bz4_bexm",    a_bexm, 0);
    check("bz4_stall",   a_stall, 5);
    check("bz4_b_stall", b_stall, 6);
    tick();
    idle();
    redirect = 1'b1;
    #2;
    check("bz5_infl",  a_infl, 3'b011);
    check("rd_flush",  a_flush, 1);
    tick();
    redirect = 1'b0;
    drain_pipe();

    // ECALL drain and halt
    drv(1, 5'd0, 0, 0, 1, 5'd0, 0, 5'd0, 0);
    #2;
    check("ec0_pc",    a_pc, 1);
    check("ec0_flush", a_flush, 0);
    tick();
    idle();
    #2;
    check("ec1_pc",    a_pc, 1);
    check("ec1_flush", a_flush, 0);
    tick();
    #2;
    check("ec2_pc",    a_pc, 0);
    check("ec2_flush", a_flush, 1);
    check("ec2_halt",  a_halted, 0);
    check("ec2_b_pc",  b_pc, 0);
    tick();
    #2 check("ec3_halt", a_halted, 0);
    tick();
    ex_busy = 1'b1;
    #2;
    check("ec4_halt",   a_halted, 1);
    check("ec4_b_halt", b_halted, 0);
    tick();
    ex_busy = 1'b0;
    #2;
    check("ec5_stall",   a_stall, 5);
    check("ec5_b_stall", b_stall, 7);
    check("ec5_b_halt",  b_halted, 1);
    tick();

    // reset clears halt, then reset again mid-drain
    rst_n = 1'b0;
    #2;
    check("rr_halt", a_halted, 0);
    check("rr_pc",   a_pc, 1);
    tick();
    rst_n = 1'b1;
    drv(1, 5'd0, 0, 0, 1, 5'd0, 0, 5'd0, 0);
    tick();
    idle();
    tick();
    #2 check("rd2_pc", a_pc, 0);
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("rd3_pc",    a_pc, 1);
    check("rd3_flush", a_flush, 0);
    check("rd3_halt",  a_halted, 0);
    check("rd3_infl",  a_infl, 0);
    check("rd3_stall", a_stall, 0);
    tick();
    rst_n = 1'b1;
    #2;
    check("rd4_halt", a_halted, 0);
    check("rd4_pc",   a_pc, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
